// File: rtl/ups_pkg.sv
// Shared types and frame geometry for the UPS ADC serial reader.
package ups_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } rd_state_t;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_LEAD_ZEROS = 4;

endpackage

// File: rtl/ups_clk_div.sv
// Half-period strobe generator: half_end pulses on the last cycle of every CLK_DIV-cycle slot.
// Counter is held at zero while en=0, so the first slot after enabling is always a full one.
module ups_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic half_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign half_end = en && (cnt == LAST);

endmodule

// File: rtl/ups_adc_reader.sv
// Periodic 16-bit SPI-style ADC reader; frame is 34*CLK_DIV cycles, result strobed as cs_n rises.
// No backpressure: ticks that land during a frame are dropped and flagged. UPS_ADC_AVG_EN adds 4-sample averaging.
module ups_adc_reader
  import ups_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     adc_cs_n,
  output logic                     adc_sclk,
  input  logic                     adc_sdo,
  output logic [ADC_DATA_BITS-1:0] adc,
  output logic                     adc_dv,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [4:0] HALF_LAST = 5'(2 * ADC_FRAME_BITS - 1);

  rd_state_t                     state;
  rd_state_t                     state_nxt;
  logic [TW-1:0]                 tick_cnt;
  logic                          tick;
  logic                          half_end;
  logic [4:0]                    half_cnt;
  logic [ADC_FRAME_BITS-1:0]     shreg;
  logic                          frame_done;
  logic                          lead_ok;
  logic                          accept;
  logic [ADC_DATA_BITS-1:0]      sample;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = enable && (tick_cnt == TICK_LAST);

  ups_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != ST_IDLE),
    .half_end (half_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (tick) state_nxt = ST_CS_SETUP;
      ST_CS_SETUP: if (half_end) state_nxt = ST_SHIFT;
      ST_SHIFT:    if (half_end && half_cnt == HALF_LAST) state_nxt = ST_CS_HOLD;
      ST_CS_HOLD:  if (half_end) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_cs_n = (state == ST_IDLE);
    adc_sclk = !(state == ST_SHIFT && !half_cnt[0]);
  end

  // Even half counts are sclk-low halves; the edge closing one is the sclk rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n || state != ST_SHIFT) begin
      half_cnt <= '0;
    end else if (half_end) begin
      half_cnt <= half_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (state == ST_SHIFT && half_end && !half_cnt[0]) begin
      shreg <= {shreg[ADC_FRAME_BITS-2:0], adc_sdo};
    end
  end

  assign frame_done = (state == ST_CS_HOLD) && half_end;
  assign lead_ok    = (shreg[ADC_FRAME_BITS-1:ADC_DATA_BITS] == '0);
  assign accept     = frame_done && lead_ok;
  assign sample     = shreg[ADC_DATA_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_done && !lead_ok;
      overrun   <= tick && (state != ST_IDLE);
    end
  end

`ifdef UPS_ADC_AVG_EN
  logic [13:0] acc;
  logic [13:0] acc_sum;
  logic [1:0]  acc_n;

  assign acc_sum = acc + {2'b00, sample};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      acc_n  <= '0;
      adc    <= '0;
      adc_dv <= 1'b0;
    end else begin
      adc_dv <= 1'b0;
      if (!enable) begin
        acc   <= '0;
        acc_n <= '0;
      end else if (accept) begin
        if (acc_n == 2'd3) begin
          adc    <= acc_sum[13:2];
          adc_dv <= 1'b1;
          acc    <= '0;
          acc_n  <= '0;
        end else begin
          acc   <= acc_sum;
          acc_n <= acc_n + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc    <= '0;
      adc_dv <= 1'b0;
    end else begin
      adc_dv <= accept;
      if (accept) begin
        adc <= sample;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ups_adc_reader.sv
// Directed bench for ups_adc_reader: table of frames plus enable-drop, mid-frame reset and overrun sequences.
`timescale 1ns/1ps
module tb_ups_adc_reader;

`ifdef UPS_ADC_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic enable_b = 1'b0;
  logic sdo = 1'b0;
  logic sdo_zero = 1'b0;
  logic cs_n, sclk, dv, err, ovr;
  logic [11:0] adc;
  logic cs50, sclk50, dv50, err50, ovr50;
  logic [11:0] adc50;
  logic cs68, sclk68, dv68, err68, ovr68;
  logic [11:0] adc68;

  always #5 clk = ~clk;

  ups_adc_reader #(.CLK_DIV(2), .SAMPLE_DIV(100)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_cs_n(cs_n), .adc_sclk(sclk),
    .adc_sdo(sdo), .adc(adc), .adc_dv(dv), .frame_err(err), .overrun(ovr));

  ups_adc_reader #(.CLK_DIV(2), .SAMPLE_DIV(50)) dut50 (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .adc_cs_n(cs50), .adc_sclk(sclk50),
    .adc_sdo(sdo_zero), .adc(adc50), .adc_dv(dv50), .frame_err(err50), .overrun(ovr50));

  ups_adc_reader #(.CLK_DIV(2), .SAMPLE_DIV(68)) dut68 (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .adc_cs_n(cs68), .adc_sclk(sclk68),
    .adc_sdo(sdo_zero), .adc(adc68), .adc_dv(dv68), .frame_err(err68), .overrun(ovr68));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ADC model: MSB driven at cs_n fall, next bit presented shortly after each sclk rise.
  logic [15:0] word = 16'h0000;
  int bitn = 15;
  always @(negedge cs_n) begin
    bitn = 15;
    sdo = word[bitn];
  end
  always @(posedge sclk) if (!cs_n) begin
    #1;
    if (bitn > 0) bitn--;
    sdo = word[bitn];
  end

  int cyc = 0, f_low = 0, f_rise = 0, dv_tot = 0, err_tot = 0, ovr_tot = 0;
  int falls = 0, last_fall = 0, prev_fall = 0;
  int dv50_n = 0, err50_n = 0, ovr50_n = 0, falls50 = 0;
  int dv68_n = 0, err68_n = 0, ovr68_n = 0, falls68 = 0;
  logic cs_prev = 1'b1, cs50_prev = 1'b1, cs68_prev = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (cs_prev && !cs_n) begin
      f_low = 0; f_rise = 0; falls++;
      prev_fall = last_fall; last_fall = cyc;
    end
    if (!cs_n) f_low++;
    if (dv) dv_tot++;
    if (err) err_tot++;
    if (ovr) ovr_tot++;
    cs_prev = cs_n;
    if (dv50) dv50_n++;
    if (err50) err50_n++;
    if (ovr50) ovr50_n++;
    if (cs50_prev && !cs50) falls50++;
    cs50_prev = cs50;
    if (dv68) dv68_n++;
    if (err68) err68_n++;
    if (ovr68) ovr68_n++;
    if (cs68_prev && !cs68) falls68++;
    cs68_prev = cs68;
  end

  always @(posedge sclk) if (!cs_n) f_rise++;

  task automatic wait_cs(input logic lvl, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (cs_n == lvl) seen = 1'b1;
    end
  endtask

  task automatic wait_strobe(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (dv || err) seen = 1'b1;
    end
  endtask

`ifndef UPS_ADC_AVG_EN
  typedef struct {
    logic [15:0] word;
    logic        exp_dv;
    logic        exp_err;
    logic [11:0] exp_adc;
  } vec_t;
  vec_t tbl [8];
`else
  logic [15:0] avg_words [4];
`endif

  bit seen;
  int d0, e0, f0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_sclk", int'(sclk), 1);
    check("rst_adc", int'(adc), 0);
    check("rst_adc_dv", int'(dv), 0);
    check("rst_frame_err", int'(err), 0);
    check("rst_overrun", int'(ovr), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_disabled_cs_n", int'(cs_n), 1);

`ifndef UPS_ADC_AVG_EN
    tbl[0] = '{16'h0ABC, 1'b1, 1'b0, 12'hABC};
    tbl[1] = '{16'h8123, 1'b0, 1'b1, 12'hABC};
    tbl[2] = '{16'h0000, 1'b1, 1'b0, 12'h000};
    tbl[3] = '{16'h0FFF, 1'b1, 1'b0, 12'hFFF};
    tbl[4] = '{16'h1FFF, 1'b0, 1'b1, 12'hFFF};
    tbl[5] = '{16'h0001, 1'b1, 1'b0, 12'h001};
    tbl[6] = '{16'hF555, 1'b0, 1'b1, 12'h001};
    tbl[7] = '{16'h0555, 1'b1, 1'b0, 12'h555};

    word = tbl[0].word;
    @(negedge clk) enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = dv_tot; e0 = err_tot;
      wait_strobe(200, seen);
      check($sformatf("v%0d_strobe_seen", i), int'(seen), 1);
      check($sformatf("v%0d_cs_n_at_strobe", i), int'(cs_n), 1);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_adc_dv_count", i), dv_tot - d0, int'(tbl[i].exp_dv));
      check($sformatf("v%0d_frame_err_count", i), err_tot - e0, int'(tbl[i].exp_err));
      check($sformatf("v%0d_adc", i), int'(adc), int'(tbl[i].exp_adc));
      check($sformatf("v%0d_cs_low_cycles", i), f_low, 68);
      check($sformatf("v%0d_sclk_rises", i), f_rise, 16);
      if (i > 0) check($sformatf("v%0d_period", i), last_fall - prev_fall, 100);
      if (i < 7) word = tbl[i+1].word;
    end

    // enable dropped in the middle of SHIFT: frame still reports, nothing follows
    word = 16'h0123;
    wait_cs(1'b0, 150, seen);
    check("drop_cs_fall_seen", int'(seen), 1);
    repeat (20) @(posedge clk);
    #1;
    enable = 1'b0;
    f0 = falls; d0 = dv_tot;
    wait_strobe(100, seen);
    check("drop_strobe_seen", int'(seen), 1);
    check("drop_adc", int'(adc), 12'h123);
    repeat (250) @(posedge clk);
    #1;
    check("drop_dv_count", dv_tot - d0, 1);
    check("drop_no_new_frame", falls - f0, 0);
`else
    avg_words[0] = 16'h0100;
    avg_words[1] = 16'h0200;
    avg_words[2] = 16'h0300;
    avg_words[3] = 16'h0404;
    d0 = dv_tot;
    word = avg_words[0];
    @(negedge clk) enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cs(1'b0, 150, seen);
      check($sformatf("avg%0d_cs_fall", k), int'(seen), 1);
      wait_cs(1'b1, 100, seen);
      check($sformatf("avg%0d_cs_rise", k), int'(seen), 1);
      if (k < 3) word = avg_words[k+1];
    end
    repeat (3) @(posedge clk);
    #1;
    check("avg_dv_count", dv_tot - d0, 1);
    check("avg_adc", int'(adc), 12'h281);
    @(negedge clk) enable = 1'b0;
    repeat (5) @(posedge clk);
`endif

    // reset asserted during the 8th sclk period
    word = 16'h0456;
    @(negedge clk) enable = 1'b1;
    wait_cs(1'b0, 150, seen);
    check("rst8_cs_fall_seen", int'(seen), 1);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clk); #1;
      if (f_rise == 7 && !sclk) seen = 1'b1;
    end
    check("rst8_reached_8th_period", int'(seen), 1);
    d0 = dv_tot; e0 = err_tot;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst8_cs_n", int'(cs_n), 1);
    check("rst8_sclk", int'(sclk), 1);
    check("rst8_adc", int'(adc), 0);
    check("rst8_adc_dv", int'(dv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    f0 = falls;
    repeat (100) @(posedge clk);
    #1;
    check("rst8_no_dv", dv_tot - d0, 0);
    check("rst8_no_err", err_tot - e0, 0);
    check("rst8_no_new_frame", falls - f0, 0);
    check("main_overrun_total", ovr_tot, 0);

    // overrun instances: SAMPLE_DIV=50 and SAMPLE_DIV=68 (tick on completion cycle)
    @(negedge clk) enable_b = 1'b1;
    repeat (460) @(posedge clk);
    #1;
    enable_b = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("ov50_frames", falls50, 5);
    check("ov50_overruns", ovr50_n, 4);
    check("ov50_adc_dv", dv50_n, AVG ? 1 : 5);
    check("ov50_frame_err", err50_n, 0);
    check("ov50_adc", int'(adc50), 0);
    check("ov68_frames", falls68, 3);
    check("ov68_overruns", ovr68_n, 3);
    check("ov68_adc_dv", dv68_n, AVG ? 0 : 3);
    check("ov68_cs_n_idle", int'(cs68), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
